// File: rtl/seq_mult_ctrl.sv
// Control FSM for the shift-add sequential multiplier: sequences load, add and
// shift strobes on a start-button rising edge and reports busy/done.
module seq_mult_ctrl #(
   parameter int unsigned DW         = 8,
   parameter int unsigned EARLY_EXIT = 1
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     start_i,
   input  logic                     mplr_lsb_i,
   input  logic                     mplr_zero_i,
   output logic                     load_o,
   output logic                     add_o,
   output logic                     shift_o,
   output logic                     busy_o,
   output logic                     done_o,
   output logic                     done_pulse_o,
   output logic [$clog2(DW):0]      iter_o
);

   localparam int unsigned IW = $clog2(DW) + 1;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_LOAD = 2'd1,
      S_CALC = 2'd2,
      S_DONE = 2'd3
   } state_e;

   state_e          state_q, state_d;
   logic [IW-1:0]   iter_q, iter_d;
   logic            start_q;
   logic            load_q, load_d;
   logic            busy_q, busy_d;
   logic            done_q, done_d;
   logic            pulse_q, pulse_d;
   logic            start_rise;
   logic            exit_c;
   logic            add_c;
   logic            shift_c;

   assign start_rise = start_i & ~start_q;
   assign exit_c     = (EARLY_EXIT != 0) && mplr_zero_i;

   // Next state, iteration count and same-cycle datapath strobes
   always_comb begin
      state_d = state_q;
      iter_d  = iter_q;
      add_c   = 1'b0;
      shift_c = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (start_rise) state_d = S_LOAD;
         end
         S_LOAD: begin
            iter_d  = '0;
            state_d = S_CALC;
         end
         S_CALC: begin
            if (exit_c) begin
               state_d = S_DONE;
            end else begin
               shift_c = 1'b1;
               add_c   = mplr_lsb_i;
               iter_d  = iter_q + IW'(1);
               if (iter_q == IW'(DW - 1)) state_d = S_DONE;
            end
         end
         S_DONE: begin
            if (start_rise) state_d = S_LOAD;
         end
         default: state_d = S_IDLE;
      endcase
   end

   // Status outputs are registered from the next state
   always_comb begin
      load_d  = (state_d == S_LOAD);
      busy_d  = (state_d == S_LOAD) || (state_d == S_CALC);
      done_d  = (state_d == S_DONE);
      pulse_d = (state_d == S_DONE) && (state_q != S_DONE);
   end

   // start_q resets high so a button held through reset is not a new press
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         iter_q  <= '0;
         start_q <= 1'b1;
         load_q  <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         pulse_q <= 1'b0;
      end else begin
         state_q <= state_d;
         iter_q  <= iter_d;
         start_q <= start_i;
         load_q  <= load_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
         pulse_q <= pulse_d;
      end
   end

   assign load_o       = load_q;
   assign add_o        = add_c;
   assign shift_o      = shift_c;
   assign busy_o       = busy_q;
   assign done_o       = done_q;
   assign done_pulse_o = pulse_q;
   assign iter_o       = iter_q;

endmodule

// File: tb/tb_seq_mult_ctrl.sv
// Scoreboard bench for seq_mult_ctrl: two instances (no early exit / early exit)
// each driving a behavioural shift-add datapath.
module tb_seq_mult_ctrl;

   typedef struct packed {
      logic [15:0] prod;
      logic [3:0]  iters;
      logic [3:0]  adds;
      logic [7:0]  lat;
      logic [31:0] pcyc;
   } exp_t;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       start_i = 1'b1;
   logic [7:0] op_a = 8'd0;
   logic [7:0] op_b = 8'd0;
   int         cyc = 0;
   int         checks = 0;
   int         errors = 0;
   exp_t       sbq [2][$];

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   function automatic void chk(input bit ok, input string name, input int inst,
                               input longint act, input longint exp_v);
      checks++;
      if (!ok) begin
         errors++;
         $display("FAIL %s dut%0d actual=%0d expected=%0d t=%0t", name, inst, act, exp_v, $time);
      end
   endfunction

   // Reference: result and timing from the operand values alone
   function automatic exp_t model(input logic [7:0] a, input logic [7:0] b,
                                  input int ee, input int pc);
      exp_t m;
      int   bl = 0;
      for (int k = 0; k < 8; k++) if (b[k]) bl = k + 1;
      m.prod  = 16'(a) * 16'(b);
      m.adds  = 4'($countones(b));
      m.iters = (ee != 0) ? 4'(bl) : 4'd8;
      m.lat   = (ee == 0 || bl == 8) ? 8'd9 : 8'(bl + 2);
      m.pcyc  = 32'(pc);
      return m;
   endfunction

   for (genvar g = 0; g < 2; g++) begin : g_dut
      logic        ld, ad, sh, bz, dn, dp, dp_prev;
      logic [3:0]  it;
      logic [15:0] mc = 16'd0;
      logic [15:0] prod = 16'd0;
      logic [7:0]  mp = 8'd0;
      int          n_add = 0;
      int          n_shift = 0;
      exp_t        e;

      seq_mult_ctrl #(.DW(8), .EARLY_EXIT(g)) u_dut (
         .clk          (clk),
         .rst_n        (rst_n),
         .start_i      (start_i),
         .mplr_lsb_i   (mp[0]),
         .mplr_zero_i  (mp == 8'd0),
         .load_o       (ld),
         .add_o        (ad),
         .shift_o      (sh),
         .busy_o       (bz),
         .done_o       (dn),
         .done_pulse_o (dp),
         .iter_o       (it)
      );

      always @(posedge clk) begin
         if (ld) begin
            mc <= 16'(op_a); mp <= op_b; prod <= 16'd0; n_add <= 0; n_shift <= 0;
         end else begin
            if (ad) begin prod <= prod + mc; n_add <= n_add + 1; end
            if (sh) begin mc <= mc << 1; mp <= mp >> 1; n_shift <= n_shift + 1; end
         end
      end

      always @(negedge clk) begin
         if (rst_n && dp) begin
            chk(dp_prev == 1'b0, "pulse_width", g, 64'(dp_prev), 0);
            if (sbq[g].size() == 0) begin
               chk(1'b0, "unexpected_done", g, 1, 0);
            end else begin
               e = sbq[g].pop_front();
               chk(prod == e.prod, "product", g, 64'(prod), 64'(e.prod));
               chk(it == e.iters, "iter_o", g, 64'(it), 64'(e.iters));
               chk(n_add == int'(e.adds), "add_count", g, 64'(n_add), 64'(e.adds));
               chk(n_shift == int'(e.iters), "shift_count", g, 64'(n_shift), 64'(e.iters));
               chk(cyc - int'(e.pcyc) == int'(e.lat), "latency", g,
                   64'(cyc - int'(e.pcyc)), 64'(e.lat));
               chk(dn == 1'b1 && bz == 1'b0, "done_busy", g, 64'({dn, bz}), 2);
            end
         end
         dp_prev <= dp;
      end
   end

   task automatic check_idle_outputs(input string name);
      chk({g_dut[0].ld, g_dut[0].ad, g_dut[0].sh, g_dut[0].bz, g_dut[0].dn, g_dut[0].dp} == 6'd0,
          name, 0, 64'({g_dut[0].ld, g_dut[0].ad, g_dut[0].sh, g_dut[0].bz, g_dut[0].dn, g_dut[0].dp}), 0);
      chk({g_dut[1].ld, g_dut[1].ad, g_dut[1].sh, g_dut[1].bz, g_dut[1].dn, g_dut[1].dp} == 6'd0,
          name, 1, 64'({g_dut[1].ld, g_dut[1].ad, g_dut[1].sh, g_dut[1].bz, g_dut[1].dn, g_dut[1].dp}), 0);
      chk(g_dut[0].it == 4'd0, "iter_zero", 0, 64'(g_dut[0].it), 0);
      chk(g_dut[1].it == 4'd0, "iter_zero", 1, 64'(g_dut[1].it), 0);
   endtask

   // Press start with operands; confirm LOAD is entered with done low
   task automatic issue(input logic [7:0] a, input logic [7:0] b);
      @(negedge clk);
      op_a = a;
      op_b = b;
      sbq[0].push_back(model(a, b, 0, cyc + 1));
      sbq[1].push_back(model(a, b, 1, cyc + 1));
      start_i = 1'b1;
      @(negedge clk);
      chk(g_dut[0].ld && g_dut[0].bz && !g_dut[0].dn, "load_state", 0,
          64'({g_dut[0].ld, g_dut[0].bz, g_dut[0].dn}), 6);
      chk(g_dut[1].ld && g_dut[1].bz && !g_dut[1].dn, "load_state", 1,
          64'({g_dut[1].ld, g_dut[1].bz, g_dut[1].dn}), 6);
   endtask

   task automatic wait_drain();
      for (int n = 0; n < 300 && (sbq[0].size() != 0 || sbq[1].size() != 0); n++)
         @(negedge clk);
      if (sbq[0].size() != 0 || sbq[1].size() != 0) begin
         chk(1'b0, "timeout", 0, 64'(sbq[0].size()), 0);
         sbq[0].delete();
         sbq[1].delete();
      end
   endtask

   task automatic run_op(input logic [7:0] a, input logic [7:0] b, input int hold);
      issue(a, b);
      repeat (hold - 1) @(negedge clk);
      start_i = 1'b0;
      wait_drain();
   endtask

   task automatic wait_iter(input logic [3:0] v);
      int n = 0;
      while (g_dut[0].it != v && n < 50) begin @(negedge clk); n++; end
      chk(g_dut[0].it == v, "reach_iter", 0, 64'(g_dut[0].it), 64'(v));
   endtask

   initial begin
      logic [7:0] a, b;
      // Start held through reset must not trigger
      repeat (3) @(negedge clk);
      check_idle_outputs("reset_outputs");
      rst_n = 1'b1;
      repeat (5) @(negedge clk);
      check_idle_outputs("held_start_after_reset");
      start_i = 1'b0;
      repeat (2) @(negedge clk);

      run_op(8'd13, 8'd11, 1);
      run_op(8'd200, 8'd3, 1);
      run_op(8'd77, 8'd0, 1);
      run_op(8'd255, 8'd255, 2);
      run_op(8'd9, 8'd128, 1);
      run_op(8'd5, 8'd1, 1);

      // Long press: exactly one operation
      run_op(8'd21, 8'd6, 50);

      for (int i = 0; i < 25; i++) begin
         a = 8'($urandom_range(0, 255));
         b = (i % 3 == 0) ? 8'($urandom_range(0, 15)) : 8'($urandom);
         run_op(a, b, int'($urandom_range(1, 4)));
      end

      // Re-press during CALC is ignored
      issue(8'd37, 8'hA5);
      @(negedge clk);
      start_i = 1'b0;
      wait_iter(4'd4);
      start_i = 1'b1;
      @(negedge clk);
      start_i = 1'b0;
      wait_drain();

      // Reset in the middle of CALC
      issue(8'd99, 8'hFF);
      @(negedge clk);
      start_i = 1'b0;
      wait_iter(4'd5);
      rst_n = 1'b0;
      #1;
      check_idle_outputs("reset_mid_calc");
      sbq[0].delete();
      sbq[1].delete();
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      repeat (3) @(negedge clk);
      check_idle_outputs("idle_after_reset");

      run_op(8'd13, 8'd11, 1);
      repeat (3) @(negedge clk);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
